// File: rtl/mfp_ahb_lite_master_arbiter.sv
// mfp_ahb_lite_master_arbiter
//
// Purpose:
//   N-master AHB-Lite arbiter placed between the bus masters (SREC loader
//   bridge, CPU, DMA engines) and mfp_ahb_lite_matrix. Holds a registered
//   one-hot grant that only changes at legal transfer boundaries. Address-phase
//   ownership (addr_owner) and data-phase ownership (data_owner) are tracked
//   separately, so a new owner can start its address phase while the previous
//   owner's last data phase is still completing.
//
// Parameters:
//   N_MASTERS       number of masters, 2..4; index 0 has highest fixed priority
//   DEFAULT_MASTER  master parked on the bus when nobody requests
//   ROUND_ROBIN     0 = fixed priority, 1 = rotate starting after the owner
//   MAX_TENURE      ownership limit in cycles (tenure build only), >= 2
//
// Build option:
//   MFP_AHB_ARB_TENURE_LIMIT_EN  adds a 9-bit saturating tenure counter. Once
//   the owner has held the bus MAX_TENURE cycles and someone else requests,
//   the owner's request is masked at the next eligible boundary. HMASTLOCK
//   still wins over the limit.
//
// Ports:
//   HCLK, HRESETn   clock, async active-low reset
//   M_REQ/M_GNT     per-master request / one-hot registered grant
//   M_H*            flattened master buses, slice i belongs to master i
//   M_HRDATA        broadcast read data
//   M_HREADY/M_HRESP  slave response to the data owner, idle response to others
//   S_H*            muxed slave-side bus toward the matrix
//   OWNER           current address owner index

module mfp_ahb_lite_master_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int DEFAULT_MASTER = 1,
  parameter int ROUND_ROBIN    = 0,
  parameter int MAX_TENURE     = 256
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,

  input  logic [N_MASTERS-1:0]    M_REQ,
  output logic [N_MASTERS-1:0]    M_GNT,

  input  logic [N_MASTERS*32-1:0] M_HADDR,
  input  logic [N_MASTERS*3-1:0]  M_HBURST,
  input  logic [N_MASTERS-1:0]    M_HMASTLOCK,
  input  logic [N_MASTERS*4-1:0]  M_HPROT,
  input  logic [N_MASTERS*3-1:0]  M_HSIZE,
  input  logic [N_MASTERS*2-1:0]  M_HTRANS,
  input  logic [N_MASTERS-1:0]    M_HWRITE,
  input  logic [N_MASTERS*32-1:0] M_HWDATA,
  output logic [31:0]             M_HRDATA,
  output logic [N_MASTERS-1:0]    M_HREADY,
  output logic [N_MASTERS-1:0]    M_HRESP,

  output logic [31:0]             S_HADDR,
  output logic [2:0]              S_HBURST,
  output logic                    S_HMASTLOCK,
  output logic [3:0]              S_HPROT,
  output logic [2:0]              S_HSIZE,
  output logic [1:0]              S_HTRANS,
  output logic                    S_HWRITE,
  output logic [31:0]             S_HWDATA,
  input  logic [31:0]             S_HRDATA,
  input  logic                    S_HREADY,
  input  logic                    S_HRESP,

  output logic [1:0]              OWNER
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic [1:0] DEF_IDX = 2'(DEFAULT_MASTER);

  // Elaboration-time parameter checks.
  generate
    if (N_MASTERS < 2 || N_MASTERS > 4) begin : g_bad_n_masters
      $error("mfp_ahb_lite_master_arbiter: N_MASTERS must be 2..4");
    end
    if (DEFAULT_MASTER < 0 || DEFAULT_MASTER >= N_MASTERS) begin : g_bad_default
      $error("mfp_ahb_lite_master_arbiter: DEFAULT_MASTER must be below N_MASTERS");
    end
    if (MAX_TENURE < 2) begin : g_bad_tenure
      $error("mfp_ahb_lite_master_arbiter: MAX_TENURE must be at least 2");
    end
  endgenerate

  // Per-master views, always 4 entries deep so a 2-bit owner index selects
  // them directly; entries beyond N_MASTERS read as zero.
  logic [31:0] haddr_a  [4];
  logic [2:0]  hburst_a [4];
  logic [3:0]  hprot_a  [4];
  logic [2:0]  hsize_a  [4];
  logic [1:0]  htrans_a [4];
  logic [31:0] hwdata_a [4];
  logic [3:0]  req4;
  logic [3:0]  lock4;
  logic [3:0]  write4;

  assign req4   = 4'(M_REQ);
  assign lock4  = 4'(M_HMASTLOCK);
  assign write4 = 4'(M_HWRITE);

  generate
    for (genvar i = 0; i < 4; i++) begin : g_unpack
      if (i < N_MASTERS) begin : g_used
        assign haddr_a[i]  = M_HADDR[i*32 +: 32];
        assign hburst_a[i] = M_HBURST[i*3 +: 3];
        assign hprot_a[i]  = M_HPROT[i*4 +: 4];
        assign hsize_a[i]  = M_HSIZE[i*3 +: 3];
        assign htrans_a[i] = M_HTRANS[i*2 +: 2];
        assign hwdata_a[i] = M_HWDATA[i*32 +: 32];
      end else begin : g_pad
        assign haddr_a[i]  = '0;
        assign hburst_a[i] = '0;
        assign hprot_a[i]  = '0;
        assign hsize_a[i]  = '0;
        assign htrans_a[i] = '0;
        assign hwdata_a[i] = '0;
      end
    end
  endgenerate

  logic [1:0]           addr_owner;
  logic [1:0]           data_owner;
  logic [1:0]           next_owner;
  logic [1:0]           winner;
  logic [N_MASTERS-1:0] gnt;
  logic [3:0]           req_eff;

  logic [1:0] own_trans;
  logic       own_lock;
  logic       own_req;
  logic       mid_burst;
  logic       eligible;

  assign own_trans = htrans_a[addr_owner];
  assign own_lock  = lock4[addr_owner];
  assign own_req   = req4[addr_owner];

  // BUSY sits inside a burst, so it blocks handover just like SEQ.
  assign mid_burst = (own_trans == HTRANS_SEQ) || (own_trans == HTRANS_BUSY);
  assign eligible  = S_HREADY && !mid_burst && !own_lock;

`ifdef MFP_AHB_ARB_TENURE_LIMIT_EN
  logic [8:0] tenure;
  logic [3:0] own_oh4;
  logic       others_req;
  logic       tenure_hit;

  assign own_oh4    = 4'b0001 << addr_owner;
  assign others_req = |(req4 & ~own_oh4);
  assign tenure_hit = (32'(tenure) >= MAX_TENURE);

  // An expired owner simply looks like a non-requester to the arbiter.
  assign req_eff = (tenure_hit && others_req) ? (req4 & ~own_oh4) : req4;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tenure <= '0;
    end else if (next_owner != addr_owner) begin
      tenure <= '0;
    end else if (tenure != 9'h1ff) begin
      tenure <= tenure + 9'd1;
    end
  end
`else
  assign req_eff = req4;
`endif

  // Winner selection. With no effective requester the bus parks on the
  // default master.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    winner = DEF_IDX;
    found  = 1'b0;
    idx    = '0;
    if (ROUND_ROBIN != 0) begin
      // Start one past the owner, owner itself is examined last.
      for (int k = 1; k <= N_MASTERS; k++) begin
        idx = 2'((int'(addr_owner) + k) % N_MASTERS);
        if (!found && req_eff[idx]) begin
          winner = idx;
          found  = 1'b1;
        end
      end
    end else begin
      // Walk downward so the lowest requesting index is written last.
      for (int k = N_MASTERS - 1; k >= 0; k--) begin
        if (req_eff[2'(k)]) begin
          winner = 2'(k);
        end
      end
    end
  end

  assign next_owner = eligible ? winner : addr_owner;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_owner <= DEF_IDX;
      data_owner <= DEF_IDX;
      gnt        <= N_MASTERS'(4'b0001 << DEF_IDX);
    end else begin
      addr_owner <= next_owner;
      gnt        <= N_MASTERS'(4'b0001 << next_owner);
      // The address phase just accepted becomes the next data phase.
      if (S_HREADY) begin
        data_owner <= addr_owner;
      end
    end
  end

  assign M_GNT = gnt;
  assign OWNER = addr_owner;

  // Address-phase mux. An owner that has dropped its request and is not in
  // the middle of a burst is presented to the slave as IDLE.
  assign S_HADDR     = haddr_a[addr_owner];
  assign S_HBURST    = hburst_a[addr_owner];
  assign S_HMASTLOCK = own_lock;
  assign S_HPROT     = hprot_a[addr_owner];
  assign S_HSIZE     = hsize_a[addr_owner];
  assign S_HWRITE    = write4[addr_owner];
  assign S_HTRANS    = (!own_req && !mid_burst) ? HTRANS_IDLE : own_trans;

  // Data-phase mux and response routing.
  assign S_HWDATA = hwdata_a[data_owner];
  assign M_HRDATA = S_HRDATA;

  generate
    for (genvar i = 0; i < N_MASTERS; i++) begin : g_resp
      assign M_HREADY[i] = (data_owner == 2'(i)) ? S_HREADY : 1'b1;
      assign M_HRESP[i]  = (data_owner == 2'(i)) ? S_HRESP  : 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_mfp_ahb_lite_master_arbiter.sv
module tb_mfp_ahb_lite_master_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic         HCLK;
  logic         HRESETn;
  logic [3:0]   req;
  logic [127:0] haddr;
  logic [11:0]  hburst;
  logic [3:0]   hlock;
  logic [15:0]  hprot;
  logic [11:0]  hsize;
  logic [7:0]   htrans;
  logic [3:0]   hwrite;
  logic [127:0] hwdata;
  logic [31:0]  s_hrdata;
  logic         s_hready;
  logic         s_hresp;

  // fixed-priority instance outputs
  logic [3:0]  gnt;
  logic [31:0] m_hrdata;
  logic [3:0]  m_hready;
  logic [3:0]  m_hresp;
  logic [31:0] s_haddr;
  logic [2:0]  s_hburst;
  logic        s_hlock;
  logic [3:0]  s_hprot;
  logic [2:0]  s_hsize;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  logic [31:0] s_hwdata;
  logic [1:0]  owner;

  // round-robin instance outputs
  logic [3:0]  gnt_r;
  logic [31:0] m_hrdata_r;
  logic [3:0]  m_hready_r;
  logic [3:0]  m_hresp_r;
  logic [31:0] s_haddr_r;
  logic [2:0]  s_hburst_r;
  logic        s_hlock_r;
  logic [3:0]  s_hprot_r;
  logic [2:0]  s_hsize_r;
  logic [1:0]  s_htrans_r;
  logic        s_hwrite_r;
  logic [31:0] s_hwdata_r;
  logic [1:0]  owner_r;

  int errors = 0;
  int checks = 0;

  mfp_ahb_lite_master_arbiter #(
    .N_MASTERS(4), .DEFAULT_MASTER(1), .ROUND_ROBIN(0), .MAX_TENURE(8)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M_REQ(req), .M_GNT(gnt),
    .M_HADDR(haddr), .M_HBURST(hburst), .M_HMASTLOCK(hlock), .M_HPROT(hprot),
    .M_HSIZE(hsize), .M_HTRANS(htrans), .M_HWRITE(hwrite), .M_HWDATA(hwdata),
    .M_HRDATA(m_hrdata), .M_HREADY(m_hready), .M_HRESP(m_hresp),
    .S_HADDR(s_haddr), .S_HBURST(s_hburst), .S_HMASTLOCK(s_hlock), .S_HPROT(s_hprot),
    .S_HSIZE(s_hsize), .S_HTRANS(s_htrans), .S_HWRITE(s_hwrite), .S_HWDATA(s_hwdata),
    .S_HRDATA(s_hrdata), .S_HREADY(s_hready), .S_HRESP(s_hresp),
    .OWNER(owner)
  );

  mfp_ahb_lite_master_arbiter #(
    .N_MASTERS(4), .DEFAULT_MASTER(1), .ROUND_ROBIN(1), .MAX_TENURE(8)
  ) dut_rr (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M_REQ(req), .M_GNT(gnt_r),
    .M_HADDR(haddr), .M_HBURST(hburst), .M_HMASTLOCK(hlock), .M_HPROT(hprot),
    .M_HSIZE(hsize), .M_HTRANS(htrans), .M_HWRITE(hwrite), .M_HWDATA(hwdata),
    .M_HRDATA(m_hrdata_r), .M_HREADY(m_hready_r), .M_HRESP(m_hresp_r),
    .S_HADDR(s_haddr_r), .S_HBURST(s_hburst_r), .S_HMASTLOCK(s_hlock_r), .S_HPROT(s_hprot_r),
    .S_HSIZE(s_hsize_r), .S_HTRANS(s_htrans_r), .S_HWRITE(s_hwrite_r), .S_HWDATA(s_hwdata_r),
    .S_HRDATA(s_hrdata), .S_HREADY(s_hready), .S_HRESP(s_hresp),
    .OWNER(owner_r)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv(input int i, input logic [1:0] tr, input logic [31:0] a,
                     input logic [31:0] wd, input logic lk, input logic wr);
    htrans[i*2 +: 2]  = tr;
    haddr[i*32 +: 32] = a;
    hwdata[i*32 +: 32] = wd;
    hlock[i]          = lk;
    hwrite[i]         = wr;
  endtask

  task automatic idle_all();
    req      = 4'b0000;
    haddr    = '0;
    hburst   = '0;
    hlock    = '0;
    hprot    = {4{4'b0011}};
    hsize    = {4{3'b010}};
    htrans   = '0;
    hwrite   = '0;
    hwdata   = '0;
    s_hrdata = 32'h0;
    s_hready = 1'b1;
    s_hresp  = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
  endtask

  initial begin
    // ---------------- 1: reset / parking ----------------
    idle_all();
    HRESETn = 1'b0;
    #7;
    chk("rst_gnt", gnt, 4'b0010);
    chk("rst_owner", owner, 2'd1);
    chk("rst_htrans", s_htrans, IDLE);
    chk("rst_gnt_rr", gnt_r, 4'b0010);
    HRESETn = 1'b1;
    tick(); tick();
    settle();
    chk("park_gnt", gnt, 4'b0010);
    // owner drives NONSEQ without requesting -> presented as IDLE
    drv(1, NONSEQ, 32'h0000_0050, 32'h0, 1'b0, 1'b0);
    settle();
    chk("noreq_idle", s_htrans, IDLE);
    s_hrdata = 32'hCAFE_F00D;
    settle();
    chk("hrdata_bcast", m_hrdata, 32'hCAFE_F00D);

    // ---------------- 2: M0 waits for M1 INCR4 burst ----------------
    do_reset();
    req = 4'b0010;
    hburst[5:3] = 3'b011;
    drv(1, NONSEQ, 32'h0000_0100, 32'h0, 1'b0, 1'b0);
    settle();
    chk("b_nseq_trans", s_htrans, NONSEQ);
    chk("b_nseq_addr", s_haddr, 32'h0000_0100);
    chk("b_burst", s_hburst, 3'b011);
    tick();
    req = 4'b0011;
    drv(1, SEQ, 32'h0000_0104, 32'h0, 1'b0, 1'b0);
    settle();
    chk("b_seq1_trans", s_htrans, SEQ);
    tick();
    settle();
    chk("b_seq1_gnt", gnt, 4'b0010);
    drv(1, SEQ, 32'h0000_0108, 32'h0, 1'b0, 1'b0);
    tick();
    settle();
    chk("b_seq2_gnt", gnt, 4'b0010);
    drv(1, SEQ, 32'h0000_010C, 32'h0, 1'b0, 1'b0);
    settle();
    chk("b_seq3_addr", s_haddr, 32'h0000_010C);
    chk("b_seq3_trans", s_htrans, SEQ);
    tick();
    drv(1, IDLE, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("b_end_gnt", gnt, 4'b0010);
    tick();
    settle();
    chk("b_handover_gnt", gnt, 4'b0001);
    chk("b_handover_own", owner, 2'd0);

    // ---------------- 3: simultaneous M0/M2 ----------------
    do_reset();
    req = 4'b0101;
    tick();
    settle();
    chk("sim_fixed_gnt", gnt, 4'b0001);
    chk("sim_rr_gnt", gnt_r, 4'b0100);
    chk("sim_rr_owner", owner_r, 2'd2);
    tick();
    settle();
    chk("sim_fixed_keep", gnt, 4'b0001);
    chk("sim_rr_next", gnt_r, 4'b0001);
    tick();
    settle();
    chk("sim_rr_wrap", gnt_r, 4'b0100);

    // ---------------- 4: wait states during M1 write ----------------
    do_reset();
    req = 4'b0010;
    drv(1, NONSEQ, 32'h0000_0200, 32'h0, 1'b0, 1'b1);
    tick();
    req = 4'b0011;
    drv(1, IDLE, 32'h0, 32'hAAAA_0001, 1'b0, 1'b1);
    drv(0, IDLE, 32'h0, 32'hBBBB_0000, 1'b0, 1'b0);
    s_hready = 1'b0;
    s_hresp  = 1'b1;
    settle();
    chk("ws_hwdata", s_hwdata, 32'hAAAA_0001);
    chk("ws_hready", m_hready, 4'b1101);
    chk("ws_hresp", m_hresp, 4'b0010);
    s_hresp = 1'b0;
    tick();
    settle();
    chk("ws1_gnt", gnt, 4'b0010);
    chk("ws1_hwdata", s_hwdata, 32'hAAAA_0001);
    tick();
    settle();
    chk("ws2_gnt", gnt, 4'b0010);
    tick();
    s_hready = 1'b1;
    settle();
    chk("ws3_gnt", gnt, 4'b0010);
    chk("ws3_hwdata", s_hwdata, 32'hAAAA_0001);
    tick();
    settle();
    chk("ws_after_gnt", gnt, 4'b0001);

    // ---------------- 5: M3 locked RMW ----------------
    do_reset();
    req = 4'b1000;
    tick();
    settle();
    chk("lk_own3", gnt, 4'b1000);
    req = 4'b1001;
    drv(3, NONSEQ, 32'h0000_0300, 32'h0, 1'b1, 1'b0);
    settle();
    chk("lk_hlock", s_hlock, 1'b1);
    tick();
    settle();
    chk("lk_rd_gnt", gnt, 4'b1000);
    drv(3, NONSEQ, 32'h0000_0300, 32'h0, 1'b1, 1'b1);
    tick();
    settle();
    chk("lk_wr_gnt", gnt, 4'b1000);
    drv(3, IDLE, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
    settle();
    chk("lk_drop_gnt", gnt, 4'b1000);
    tick();
    settle();
    chk("lk_release_gnt", gnt, 4'b0001);

    // asynchronous reset in the middle of a cycle
    #1;
    HRESETn = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 4'b0010);
    chk("async_rst_own", owner, 2'd1);

    // ---------------- 6: tenure limit ----------------
    do_reset();
    req = 4'b0110;
    for (int c = 0; c < 8; c++) begin
      drv(1, NONSEQ, 32'h0000_0400 + 32'(c * 4), 32'h0, 1'b0, 1'b0);
      tick();
    end
    settle();
    chk("ten_before", gnt, 4'b0010);
    tick();
    settle();
`ifdef MFP_AHB_ARB_TENURE_LIMIT_EN
    chk("ten_after", gnt, 4'b0100);
`else
    chk("ten_after", gnt, 4'b0010);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
